// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the Counters project set.
//   DIR_UP / DIR_DN   : values of the up_dn direction input
//   MODE_WRAP/MODE_SAT: values of the SATURATE parameter
//   clamp_mod()       : limits a value to the range 0..modulus-1
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // 33 bits so that a modulus of 2**32 still fits.
  function automatic logic [32:0] clamp_mod(input logic [32:0] value,
                                            input logic [32:0] modulus);
    if (value >= modulus)
      return modulus - 33'd1;
    else
      return value;
  endfunction

endpackage

// File: rtl/sync_updown_counter_mod_if.sv
// sync_updown_counter_mod_if
// Control and status bundle of the up/down counter.
//   en, up_dn, load, load_val : driven by the controlling side (master)
//   q, tc, wrap, sat          : driven by the counter (slave)
interface sync_updown_counter_mod_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             sat;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, wrap, sat
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, wrap, sat
  );

endinterface

// File: rtl/counter_next_val.sv
// counter_next_val
// Combinational next-state logic of the up/down counter.
//   q        : current count
//   up_dn    : direction, 1 = up, 0 = down
//   en       : count enable
//   load     : parallel load strobe (wins over en)
//   load_val : value to load, clamped into range
//   next_q   : count for the next edge
//   wrap_ev  : this edge wraps around a limit
//   sat_ev   : this enabled edge is pinned at a limit (SATURATE mode)
//   tc       : en high and q at the limit for the current direction
module counter_next_val
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 10,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap_ev,
  output logic             sat_ev,
  output logic             tc
);

  // One extra bit keeps MODULUS = 2**WIDTH representable in the compares.
  localparam logic [WIDTH:0] MAX_Q = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] nxt_ext;

  assign q_ext = {1'b0, q};

  always_comb begin
    nxt_ext = q_ext;
    wrap_ev = 1'b0;
    sat_ev  = 1'b0;
    if (load) begin
      nxt_ext = (WIDTH+1)'(clamp_mod(33'(load_val), 33'(MODULUS)));
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (q_ext < MAX_Q) begin
          nxt_ext = q_ext + ONE;
        end else if (SATURATE == MODE_SAT) begin
          sat_ev = 1'b1;
        end else begin
          nxt_ext = '0;
          wrap_ev = 1'b1;
        end
      end else begin
        if (q_ext != '0) begin
          nxt_ext = q_ext - ONE;
        end else if (SATURATE == MODE_SAT) begin
          sat_ev = 1'b1;
        end else begin
          nxt_ext = MAX_Q;
          wrap_ev = 1'b1;
        end
      end
    end
  end

  // nxt_ext never exceeds MAX_Q, so its top bit is always zero.
  assign next_q = WIDTH'(nxt_ext);

  assign tc = en & ((up_dn == DIR_UP) ? (q_ext == MAX_Q) : (q_ext == '0));

endmodule

// File: rtl/sync_updown_counter_mod.sv
// sync_updown_counter_mod
// Parametrised up/down counter with load, wrap or saturate mode and flags.
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : slave side of sync_updown_counter_mod_if
//         (en, up_dn, load, load_val in; q, tc, wrap, sat out)
module sync_updown_counter_mod
  import counter_pkg::*;
#(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 10,
  parameter longint RESET_VAL = 0,
  parameter int     SATURATE  = MODE_WRAP
) (
  input logic                   clk,
  input logic                   rst,
  sync_updown_counter_mod_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "sync_updown_counter_mod: WIDTH must be 2..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $fatal(1, "sync_updown_counter_mod: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $fatal(1, "sync_updown_counter_mod: RESET_VAL must be below MODULUS");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $fatal(1, "sync_updown_counter_mod: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             sat_r;
  logic [WIDTH-1:0] next_q;
  logic             wrap_ev;
  logic             sat_ev;
  logic             tc;

  counter_next_val #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .q        (q_r),
    .up_dn    (bus.up_dn),
    .en       (bus.en),
    .load     (bus.load),
    .load_val (bus.load_val),
    .next_q   (next_q),
    .wrap_ev  (wrap_ev),
    .sat_ev   (sat_ev),
    .tc       (tc)
  );

  // sat only changes on load or enabled edges; idle edges keep it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= RST_Q;
      wrap_r <= 1'b0;
      sat_r  <= 1'b0;
    end else begin
      q_r    <= next_q;
      wrap_r <= wrap_ev;
      if (bus.load)
        sat_r <= 1'b0;
      else if (bus.en)
        sat_r <= sat_ev;
    end
  end

  assign bus.q    = q_r;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_r;
  assign bus.sat  = sat_r;

endmodule

// File: tb/tb_sync_updown_counter_mod.sv
// tb_sync_updown_counter_mod
// Exercises three counter instances sharing clk/rst:
//   0: WIDTH=3, MODULUS=8,  wrap mode
//   1: WIDTH=4, MODULUS=10, wrap mode (defaults)
//   2: WIDTH=4, MODULUS=10, saturate mode
// Expected q/wrap/sat come from a behavioural model and pass through a
// scoreboard queue; tc is compared against the model before each edge.
module tb_sync_updown_counter_mod;

  typedef struct {
    int d;
    int q;
    int w;
    int s;
  } exp_t;

  logic clk;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  int mMod[3]  = '{8, 10, 10};
  int mSatM[3] = '{0, 0, 1};
  int mq[3];
  int mw[3];
  int ms[3];
  int inEn[3];
  int inUp[3];
  int inLoad[3];
  int inLv[3];

  exp_t sb[$];

  sync_updown_counter_mod_if #(.WIDTH(3)) if_a ();
  sync_updown_counter_mod_if #(.WIDTH(4)) if_b ();
  sync_updown_counter_mod_if #(.WIDTH(4)) if_c ();

  sync_updown_counter_mod #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0), .SATURATE(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  sync_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  sync_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int d, input int e, input int u, input int l, input int lv);
    inEn[d] = e; inUp[d] = u; inLoad[d] = l; inLv[d] = lv;
    case (d)
      0: begin
        if_a.en = e[0]; if_a.up_dn = u[0]; if_a.load = l[0]; if_a.load_val = 3'(lv);
      end
      1: begin
        if_b.en = e[0]; if_b.up_dn = u[0]; if_b.load = l[0]; if_b.load_val = 4'(lv);
      end
      default: begin
        if_c.en = e[0]; if_c.up_dn = u[0]; if_c.load = l[0]; if_c.load_val = 4'(lv);
      end
    endcase
  endtask

  task automatic getOut(input int d, output int q, output int tc, output int w, output int s);
    case (d)
      0: begin q = int'(if_a.q); tc = int'(if_a.tc); w = int'(if_a.wrap); s = int'(if_a.sat); end
      1: begin q = int'(if_b.q); tc = int'(if_b.tc); w = int'(if_b.wrap); s = int'(if_b.sat); end
      default: begin q = int'(if_c.q); tc = int'(if_c.tc); w = int'(if_c.wrap); s = int'(if_c.sat); end
    endcase
  endtask

  function automatic int modelTc(input int d);
    if (inEn[d] == 0) return 0;
    if (inUp[d] != 0) return (mq[d] == mMod[d] - 1) ? 1 : 0;
    return (mq[d] == 0) ? 1 : 0;
  endfunction

  function automatic void stepModel(input int d);
    if (inLoad[d] != 0) begin
      mq[d] = (inLv[d] >= mMod[d]) ? mMod[d] - 1 : inLv[d];
      mw[d] = 0;
      ms[d] = 0;
    end else if (inEn[d] != 0) begin
      mw[d] = 0;
      if (inUp[d] != 0) begin
        if (mq[d] < mMod[d] - 1) begin
          mq[d] = mq[d] + 1; ms[d] = 0;
        end else if (mSatM[d] != 0) begin
          ms[d] = 1;
        end else begin
          mq[d] = 0; mw[d] = 1; ms[d] = 0;
        end
      end else begin
        if (mq[d] > 0) begin
          mq[d] = mq[d] - 1; ms[d] = 0;
        end else if (mSatM[d] != 0) begin
          ms[d] = 1;
        end else begin
          mq[d] = mMod[d] - 1; mw[d] = 1; ms[d] = 0;
        end
      end
    end else begin
      mw[d] = 0;
    end
  endfunction

  task automatic checkTcAll();
    int q, tc, w, s;
    #1;
    for (int d = 0; d < 3; d++) begin
      getOut(d, q, tc, w, s);
      checkOutput($sformatf("tc[%0d] q=%0d", d, mq[d]), tc, modelTc(d));
    end
  endtask

  task automatic checkState(input string tag);
    int q, tc, w, s;
    for (int d = 0; d < 3; d++) begin
      getOut(d, q, tc, w, s);
      checkOutput($sformatf("%s q[%0d]", tag, d), q, mq[d]);
      checkOutput($sformatf("%s wrap[%0d]", tag, d), w, mw[d]);
      checkOutput($sformatf("%s sat[%0d]", tag, d), s, ms[d]);
    end
  endtask

  task automatic resetModel();
    for (int d = 0; d < 3; d++) begin
      mq[d] = 0; mw[d] = 0; ms[d] = 0;
    end
  endtask

  // One clock edge: check tc, push expectations, clock, pop and compare.
  task automatic tick();
    exp_t e;
    int q, tc, w, s;
    checkTcAll();
    for (int d = 0; d < 3; d++) begin
      stepModel(d);
      sb.push_back('{d: d, q: mq[d], w: mw[d], s: ms[d]});
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      getOut(e.d, q, tc, w, s);
      checkOutput($sformatf("q[%0d]", e.d), q, e.q);
      checkOutput($sformatf("wrap[%0d]", e.d), w, e.w);
      checkOutput($sformatf("sat[%0d]", e.d), s, e.s);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) applyStimulus(d, 0, 0, 0, 0);
    resetModel();
    #7;
    checkState("reset");
    #3;
    rst = 1'b1;

    // Down count with wrap on the 3-bit, modulus-8 instance.
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    applyStimulus(0, 0, 0, 0, 0);

    // Up count through the default modulus-10 wrap.
    applyStimulus(1, 1, 1, 0, 0);
    for (int i = 0; i < 11; i++) tick();
    applyStimulus(1, 0, 1, 0, 0);

    // Saturate: load 8, count up into the limit, then step back down.
    applyStimulus(2, 0, 1, 1, 8);
    tick();
    applyStimulus(2, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(2, 1, 0, 0, 0);
    tick();
    applyStimulus(2, 0, 0, 0, 0);
    tick();

    // Load clamping and load priority over en.
    applyStimulus(1, 0, 1, 1, 13);
    tick();
    applyStimulus(1, 1, 1, 1, 3);
    tick();

    // Count to 5, then assert reset between clock edges.
    applyStimulus(1, 1, 1, 0, 0);
    tick();
    tick();
    #3;
    rst = 1'b0;
    resetModel();
    #1;
    checkState("async_rst");
    @(posedge clk);
    #1;
    checkState("rst_held");
    #4;
    rst = 1'b1;
    tick();

    // en pattern 1,0,0,1 from q=2.
    applyStimulus(1, 0, 1, 1, 2);
    tick();
    applyStimulus(1, 1, 1, 0, 0); tick();
    applyStimulus(1, 0, 1, 0, 0); tick();
    applyStimulus(1, 0, 1, 0, 0); tick();
    applyStimulus(1, 1, 1, 0, 0); tick();

    // tc follows up_dn combinationally at q=0.
    applyStimulus(1, 0, 1, 1, 0);
    tick();
    applyStimulus(1, 1, 1, 0, 0);
    checkTcAll();
    applyStimulus(1, 1, 0, 0, 0);
    checkTcAll();
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter_mod.md
Name: sync_updown_counter_mod

Overview:
- Parametrised synchronous counter; next generation of the team's fixed 3-bit down counter.
- Adds configurable width and modulus, run-time up/down direction, count enable, parallel load, wrap or saturate mode, and terminal-count/wrap flags.
- Used as a generic timebase/index counter in the Counters project set; directly replaces the fixed up and down counters.

Parameters:
- WIDTH, 4, counter register width in bits (2..32).
- MODULUS, 10, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- RESET_VAL, 0, value of q after reset; must be < MODULUS.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- en  input  1  count enable; one step per clk edge while high
- up_dn  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value loaded when load=1
- q  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational: en=1 and q at the limit for the current direction
- wrap  output  1  registered one-cycle pulse, high for the cycle after a wrap occurs
- sat  output  1  registered level: q is pinned at a limit because of SATURATE=1

Behaviour:
- Reset (rst=0, asynchronous, any time, including mid-count or mid-load):
  - q = RESET_VAL, wrap = 0, sat = 0.
  - Release is synchronous to the next clk edge; the first count happens on the first edge with rst=1 and en=1.
- Priority at each rising edge: reset > load > en > hold.
- Load:
  - q <= load_val, clamped to MODULUS-1 when load_val >= MODULUS.
  - wrap <= 0; sat <= 0.
  - en is ignored in a load cycle.
- Count up (en=1, up_dn=1):
  - q < MODULUS-1: q <= q+1.
  - q = MODULUS-1, SATURATE=0: q <= 0, wrap <= 1.
  - q = MODULUS-1, SATURATE=1: q holds, sat <= 1.
- Count down (en=1, up_dn=0):
  - q > 0: q <= q-1.
  - q = 0, SATURATE=0: q <= MODULUS-1, wrap <= 1.
  - q = 0, SATURATE=1: q holds, sat <= 1.
- Hold (en=0, load=0): q holds, wrap <= 0, sat holds.
- wrap is high for exactly one cycle per wrap event and is cleared on any non-wrapping edge.
- sat clears on the first edge that moves q away from the limit, on load, or on reset.
- tc limit is MODULUS-1 when up_dn=1 and 0 when up_dn=0; it follows up_dn combinationally.
- A direction change takes effect on the same edge; no pipeline or latency penalty.
- Arithmetic:
  - Next-value logic is WIDTH+1 bits wide, so MODULUS = 2**WIDTH cannot overflow the comparison.
  - q never takes a value >= MODULUS.
- Elaboration must fail (generate-time check) for illegal MODULUS or RESET_VAL.

Decomposition:
- Shared package counter_pkg:
  - direction constants DIR_UP=1, DIR_DN=0
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - function clamp_mod(value, modulus), reused by the other counters
- One natural sub-module, counter_next_val (combinational):
  - inputs: q, up_dn, en, load, load_val
  - outputs: next_q, wrap_ev, sat_ev, tc
  - the top level holds only the registers.

Test Plan:
- WIDTH=3, MODULUS=8, RESET_VAL=0, en=1, up_dn=0, rst low for 10 ns then high:
  - q = 0,7,6,5,4,3,2,1,0,7; wrap high only in the cycle after each 0->7 step.
- Defaults (MODULUS=10), up_dn=1, en=1 from reset:
  - q = 0..9,0; tc=1 only while q=9; one wrap pulse after 9->0.
- SATURATE=1, MODULUS=10, load=1 with load_val=8, then count up 4 edges:
  - q = 8,9,9,9; sat rises after the first hold edge.
  - Then up_dn=0: q = 8 and sat clears.
- load_val=13 with MODULUS=10 -> q=9.
  - load=1 and en=1 together with load_val=3 -> q=3 (load wins, no count).
- Count up to q=5, assert rst=0 midway between clk edges:
  - q=0, wrap=0, sat=0 immediately, without waiting for a clk edge.
  - After release, en=1 gives q=1 on the first edge.
- en toggled 1,0,0,1 with up_dn=1 from q=2:
  - q = 3,3,3,4; tc stays 0; flipping up_dn at q=0 gives tc=1 combinationally while en=1.
